alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 145 ++++++++++++++
 tb/tb_alu_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared combinational ALU.
// One operation is in flight at a time: IDLE grants and latches a request,
// EXEC captures the ALU result, RESP holds it until the owner consumes it.
// FAIR=1 alternates between requesters under contention; FAIR=0 always
// prefers requester 0.
module alu_arbiter #(
    parameter int unsigned FAIR = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_ctr,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_ctr,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_out,

    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_out,

    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctr,
    input  logic [31:0] alu_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [3:0]  r_ctr;
    logic [31:0] r_res;
    logic        r_owner;   // requester whose operation is in flight
    logic        r_last;    // requester served most recently
    logic        w_grant;   // requester that would win in IDLE this cycle
    logic        w_hs;      // request handshake this cycle
    logic        w_done;    // owner consumes the response this cycle

    // Arbitration: contention goes to the requester not served last (FAIR)
    // or to requester 0; a lone requester always wins.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it unassigned, which would infer a latch.
        w_grant = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant = (FAIR != 0) ? ~r_last : 1'b0;
        end else if (req1_valid) begin
            w_grant = 1'b1;
        end
    end

    // Next-state logic and handshake outputs of the IDLE/EXEC/RESP sequence.
    always_comb begin
        w_next     = r_state;
        w_hs       = 1'b0;
        w_done     = 1'b0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                req0_ready = req0_valid && !w_grant;
                req1_ready = req1_valid &&  w_grant;
                if (req0_valid || req1_valid) begin
                    w_hs   = 1'b1;
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                rsp0_valid = !r_owner;
                rsp1_valid =  r_owner;
                // The non-owner's ready is deliberately not looked at.
                w_done = r_owner ? rsp1_ready : rsp0_ready;
                if (w_done) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // State register; reset abandons any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            // NOTE: registers are updated with non-blocking assignments so every flop samples pre-edge values.
            r_state <= w_next;
        end
    end

    // Operand, result, owner and last-served registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_ctr   <= '0;
            r_res   <= '0;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            if (w_hs) begin
                r_a     <= w_grant ? req1_a   : req0_a;
                r_b     <= w_grant ? req1_b   : req0_b;
                r_ctr   <= w_grant ? req1_ctr : req0_ctr;
                r_owner <= w_grant;
            end
            if (r_state == S_EXEC) begin
                r_res <= alu_out;
            end
            if (w_done) begin
                r_last <= r_owner;
            end
        end
    end

    assign alu_a    = r_a;
    assign alu_b    = r_b;
    assign alu_ctr  = r_ctr;
    assign rsp0_out = r_res;
    assign rsp1_out = r_res;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter. Instance 0 is round-robin (FAIR=1),
// instance 1 is fixed priority (FAIR=0); each has its own behavioural ALU.
// Stimulus pushes expected responses; a negedge monitor pops and compares
// every response the DUTs deliver.
module tb_alu_arbiter;

    typedef struct {
        int          port;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;

    logic        req0_valid [2];
    logic        req0_ready [2];
    logic [31:0] req0_a     [2];
    logic [31:0] req0_b     [2];
    logic [3:0]  req0_ctr   [2];
    logic        req1_valid [2];
    logic        req1_ready [2];
    logic [31:0] req1_a     [2];
    logic [31:0] req1_b     [2];
    logic [3:0]  req1_ctr   [2];
    logic        rsp0_valid [2];
    logic        rsp0_ready [2];
    logic [31:0] rsp0_out   [2];
    logic        rsp1_valid [2];
    logic        rsp1_ready [2];
    logic [31:0] rsp1_out   [2];
    logic [31:0] alu_a      [2];
    logic [31:0] alu_b      [2];
    logic [3:0]  alu_ctr    [2];
    logic [31:0] alu_out    [2];

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Small reference ALU: 0000 add, 1000 sub, 0001 and, otherwise or.
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] c);
        case (c)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0001: return a & b;
            default: return a | b;
        endcase
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        assign alu_out[k] = ref_alu(alu_a[k], alu_b[k], alu_ctr[k]);

        alu_arbiter #(.FAIR((k == 0) ? 1 : 0)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .req0_valid (req0_valid[k]),
            .req0_ready (req0_ready[k]),
            .req0_a     (req0_a[k]),
            .req0_b     (req0_b[k]),
            .req0_ctr   (req0_ctr[k]),
            .req1_valid (req1_valid[k]),
            .req1_ready (req1_ready[k]),
            .req1_a     (req1_a[k]),
            .req1_b     (req1_b[k]),
            .req1_ctr   (req1_ctr[k]),
            .rsp0_valid (rsp0_valid[k]),
            .rsp0_ready (rsp0_ready[k]),
            .rsp0_out   (rsp0_out[k]),
            .rsp1_valid (rsp1_valid[k]),
            .rsp1_ready (rsp1_ready[k]),
            .rsp1_out   (rsp1_out[k]),
            .alu_a      (alu_a[k]),
            .alu_b      (alu_b[k]),
            .alu_ctr    (alu_ctr[k]),
            .alu_out    (alu_out[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input int port, input logic [31:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        if (k == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    task automatic set_req0(input int k, input logic v, input logic [31:0] a,
                            input logic [31:0] b, input logic [3:0] c);
        req0_valid[k] = v; req0_a[k] = a; req0_b[k] = b; req0_ctr[k] = c;
    endtask

    task automatic set_req1(input int k, input logic v, input logic [31:0] a,
                            input logic [31:0] b, input logic [3:0] c);
        req1_valid[k] = v; req1_a[k] = a; req1_b[k] = b; req1_ctr[k] = c;
    endtask

    // Monitor: every delivered response must match the head of its scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                int          port;
                logic [31:0] got;
                exp_t        e;
                port = -1;
                got  = '0;
                if (rsp0_valid[k] && rsp0_ready[k]) begin
                    port = 0; got = rsp0_out[k];
                end else if (rsp1_valid[k] && rsp1_ready[k]) begin
                    port = 1; got = rsp1_out[k];
                end
                if (port >= 0) begin
                    if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
                        check($sformatf("unexpected_rsp_dut%0d_port%0d", k, port), got, 32'hdead_beef);
                    end else begin
                        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check($sformatf("rsp_port_dut%0d", k), 32'(port), 32'(e.port));
                        check($sformatf("rsp_data_dut%0d", k), got, e.data);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_req0(k, 1'b0, '0, '0, '0);
            set_req1(k, 1'b0, '0, '0, '0);
            rsp0_ready[k] = 1'b1;
            rsp1_ready[k] = 1'b1;
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state.
        check("reset_rsp0_valid", 32'(rsp0_valid[0]), 0);
        check("reset_rsp1_valid", 32'(rsp1_valid[0]), 0);
        check("reset_alu_a", alu_a[0], 0);
        check("reset_alu_b", alu_b[0], 0);
        check("reset_alu_ctr", 32'(alu_ctr[0]), 0);
        check("reset_req0_ready_idle", 32'(req0_ready[0]), 0);

        // Single op: 3 + 5 on requester 0.
        set_req0(0, 1'b1, 3, 5, 4'b0000);
        #1;
        check("single_req0_ready", 32'(req0_ready[0]), 1);
        check("single_req1_ready", 32'(req1_ready[0]), 0);
        push(0, 0, 8);
        tick();
        req0_valid[0] = 1'b0;
        check("single_exec_ready", 32'(req0_ready[0]), 0);
        check("single_alu_a", alu_a[0], 3);
        check("single_alu_b", alu_b[0], 5);
        check("single_rsp0_valid_early", 32'(rsp0_valid[0]), 0);
        tick();
        check("single_rsp0_valid", 32'(rsp0_valid[0]), 1);
        check("single_rsp1_valid", 32'(rsp1_valid[0]), 0);
        check("single_rsp1_out_mirror", rsp1_out[0], 8);
        tick();

        // Contention, FAIR=1, fresh reset: grants 0,1,0.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        set_req0(0, 1'b1, 10, 4, 4'b1000);
        set_req1(0, 1'b1, 1, 1, 4'b0000);
        #1;
        check("rr_first_grant0", 32'(req0_ready[0]), 1);
        check("rr_first_grant1", 32'(req1_ready[0]), 0);
        push(0, 0, 6);
        push(0, 1, 2);
        push(0, 0, 6);
        tick();
        check("rr_exec_no_ready0", 32'(req0_ready[0]), 0);
        check("rr_exec_no_ready1", 32'(req1_ready[0]), 0);
        repeat (8) tick();
        check("rr_next_grant1", 32'(req1_ready[0]), 1);
        req0_valid[0] = 1'b0;
        req1_valid[0] = 1'b0;

        // FAIR=0: requester 0 wins three times, requester 1 once it drops.
        set_req0(1, 1'b1, 10, 4, 4'b1000);
        set_req1(1, 1'b1, 1, 1, 4'b0000);
        push(1, 0, 6);
        push(1, 0, 6);
        push(1, 0, 6);
        repeat (9) tick();
        check("fp_req1_starved", 32'(req1_ready[1]), 0);
        check("fp_req0_again", 32'(req0_ready[1]), 1);
        req0_valid[1] = 1'b0;
        #1;
        check("fp_req1_granted", 32'(req1_ready[1]), 1);
        push(1, 1, 2);
        tick();
        req1_valid[1] = 1'b0;
        tick();
        tick();

        // Backpressure: owner holds off 5 cycles, non-owner ready ignored.
        rsp0_ready[0] = 1'b0;
        set_req0(0, 1'b1, 7, 2, 4'b1000);
        #1;
        check("bp_grant0", 32'(req0_ready[0]), 1);
        tick();
        req0_valid[0] = 1'b0;
        set_req1(0, 1'b1, 20, 5, 4'b0000);
        #1;
        check("bp_exec_req1_ready", 32'(req1_ready[0]), 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_rsp0_valid_%0d", i), 32'(rsp0_valid[0]), 1);
            check($sformatf("bp_rsp0_out_%0d", i), rsp0_out[0], 5);
            check($sformatf("bp_req1_ready_%0d", i), 32'(req1_ready[0]), 0);
            check($sformatf("bp_alu_a_%0d", i), alu_a[0], 7);
            tick();
        end
        push(0, 0, 5);
        push(0, 1, 25);
        rsp0_ready[0] = 1'b1;
        tick();
        check("bp_then_req1_ready", 32'(req1_ready[0]), 1);
        tick();
        req1_valid[0] = 1'b0;
        tick();
        tick();

        // Payload changes after the handshake must not leak in.
        set_req0(0, 1'b1, 9, 3, 4'b0000);
        push(0, 0, 12);
        tick();
        set_req0(0, 1'b0, 100, 50, 4'b1000);
        #1;
        check("payload_alu_a", alu_a[0], 9);
        check("payload_alu_ctr", 32'(alu_ctr[0]), 0);
        tick();
        tick();

        // Reset in EXEC (n=0) and in RESP (n=1): nothing comes out afterwards.
        for (int n = 0; n < 2; n++) begin
            rsp0_ready[0] = 1'b0;
            set_req0(0, 1'b1, 1, 2, 4'b0000);
            tick();
            req0_valid[0] = 1'b0;
            if (n == 1) begin
                tick();
                check("rst_resp_valid_before", 32'(rsp0_valid[0]), 1);
            end
            rst_n = 1'b0;
            #1;
            check($sformatf("rst%0d_rsp0_valid", n), 32'(rsp0_valid[0]), 0);
            check($sformatf("rst%0d_alu_a", n), alu_a[0], 0);
            tick();
            rst_n = 1'b1;
            rsp0_ready[0] = 1'b1;
            repeat (3) tick();
            check($sformatf("rst%0d_no_rsp", n), 32'(rsp0_valid[0]), 0);
            set_req0(0, 1'b1, 10, 4, 4'b1000);
            set_req1(0, 1'b1, 1, 1, 4'b0000);
            #1;
            check($sformatf("rst%0d_grant0", n), 32'(req0_ready[0]), 1);
            check($sformatf("rst%0d_grant1", n), 32'(req1_ready[0]), 0);
            push(0, 0, 6);
            tick();
            req0_valid[0] = 1'b0;
            req1_valid[0] = 1'b0;
            tick();
            tick();
        end

        repeat (3) tick();
        check("scoreboard0_drained", 32'(exp_q0.size()), 0);
        check("scoreboard1_drained", 32'(exp_q1.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
